// File: rtl/lif_pkg.sv
// lif_pkg: frame layout and FSM state encoding shared by the LIF parameter
// sender and the parameter-loader receiver.
//   Frame (24 bits, MSB first on the wire):
//     [23:16] weight byte    = {5'b0, weight[2:0]}
//     [15:8]  leak byte      = {6'b0, leak[1:0]}
//     [7:0]   threshold byte = threshold[7:0]
package lif_pkg;

  localparam int FRAME_BITS = 24;
  localparam int WEIGHT_W   = 3;
  localparam int LEAK_W     = 2;
  localparam int THR_W      = 8;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  // Bit positions of each field inside the frame.
  localparam int WEIGHT_LSB = 16;
  localparam int LEAK_LSB   = 8;
  localparam int THR_LSB    = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_GAP      = 2'd3
  } lif_state_e;

  function automatic logic [FRAME_BITS-1:0] lif_pack_frame(
    input logic [WEIGHT_W-1:0] weight,
    input logic [LEAK_W-1:0]   leak,
    input logic [THR_W-1:0]    thr
  );
    return {5'b0, weight, 6'b0, leak, thr};
  endfunction

endpackage

// File: rtl/lif_piso_shift24.sv
// lif_piso_shift24: parallel-load frame register with a down-counting bit
// pointer. bit_o is the frame bit currently selected (MSB first).
//   clk, reset : clock, synchronous active-high reset
//   load_i     : capture frame_i
//   frame_i    : frame to send
//   arm_i      : point at the MSB (FRAME_BITS-1)
//   step_i     : advance to the next lower bit (saturates at 0)
//   bit_o      : frame[pointer]
//   last_o     : pointer is at bit 0
module lif_piso_shift24
  import lif_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [FRAME_BITS-1:0] frame_i,
  input  logic                  arm_i,
  input  logic                  step_i,
  output logic                  bit_o,
  output logic                  last_o
);

  logic [FRAME_BITS-1:0] frame_q;
  logic [CNT_W-1:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (load_i) frame_q <= frame_i;
      if (arm_i)
        cnt_q <= CNT_W'(FRAME_BITS - 1);
      else if (step_i && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bit_o  = frame_q[cnt_q];
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/lif_param_sender.sv
// lif_param_sender: serialises one {weight, leak, threshold} parameter frame
// to the parameter-loader receiver. One preamble tick (load_enable high, data
// idle), 24 data ticks MSB first, then GAP_TICKS ticks with load_enable low.
//   clk, reset      : clock, synchronous active-high reset
//   tick            : bit-rate enable; the frame only advances on tick cycles
//   start           : request a frame (accepted in IDLE when done is low)
//   weight_in/leak_in/threshold_in : parameters latched on the accept cycle
//   serial_data_out : registered serial data
//   load_enable_out : registered frame-valid strobe
//   busy            : frame in progress
//   done            : one-clk pulse on the final gap tick
//   start_dropped   : one-clk pulse when start is ignored
module lif_param_sender
  import lif_pkg::*;
#(
  parameter int   GAP_TICKS = 2,
  parameter logic IDLE_DATA = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start,
  input  logic [WEIGHT_W-1:0] weight_in,
  input  logic [LEAK_W-1:0]   leak_in,
  input  logic [THR_W-1:0]    threshold_in,
  output logic                serial_data_out,
  output logic                load_enable_out,
  output logic                busy,
  output logic                done,
  output logic                start_dropped
);

  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  lif_state_e       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             sdo_q, sdo_d;
  logic             le_q, le_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic             load, arm, step;
  logic             shift_bit, shift_last;

  lif_piso_shift24 u_piso (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .frame_i (lif_pack_frame(weight_in, leak_in, threshold_in)),
    .arm_i   (arm),
    .step_i  (step),
    .bit_o   (shift_bit),
    .last_o  (shift_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      sdo_q   <= IDLE_DATA;
      le_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      sdo_q   <= sdo_d;
      le_q    <= le_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    sdo_d   = sdo_q;
    le_d    = le_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    // The done cycle is already idle, but a start there is still refused so
    // a new frame always needs start while both busy and done are low.
    drop_d  = start && (busy_q || done_q);
    load    = 1'b0;
    arm     = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (tick) begin
          le_d    = 1'b1;
          sdo_d   = IDLE_DATA;
          arm     = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          le_d  = 1'b1;
          sdo_d = shift_bit;
          step  = 1'b1;
          // Bit 0 goes out on this tick; the next tick already belongs to GAP.
          if (shift_last) begin
            state_d = ST_GAP;
            gap_d   = GAP_W'(GAP_TICKS);
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          le_d  = 1'b0;
          sdo_d = IDLE_DATA;
          gap_d = gap_q - 1'b1;
          if (gap_q == GAP_W'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            gap_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign serial_data_out = sdo_q;
  assign load_enable_out = le_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign start_dropped   = drop_q;

endmodule

// File: tb/tb_lif_param_sender.sv
// Self-checking bench for lif_param_sender. A tick-count model predicts every
// output each cycle; directed scenarios add literal expectations on the
// received bit stream, latencies and pulse counts.
module tb_lif_param_sender;

  localparam int   GAP  = 2;
  localparam logic IDLE = 1'b0;

  logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, start = 1'b0;
  logic [2:0] w = '0;
  logic [1:0] lk = '0;
  logic [7:0] thr = '0;
  logic       sdo, le, busy, done, drop;

  lif_param_sender #(.GAP_TICKS(GAP), .IDLE_DATA(IDLE)) dut (
    .clk             (clk),
    .reset           (reset),
    .tick            (tick),
    .start           (start),
    .weight_in       (w),
    .leak_in         (lk),
    .threshold_in    (thr),
    .serial_data_out (sdo),
    .load_enable_out (le),
    .busy            (busy),
    .done            (done),
    .start_dropped   (drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int tick_mode = 0;  // 0: always, 1: every 4th clk, 2: held low
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    case (tick_mode)
      0:       tick = 1'b1;
      1:       tick = (cyc % 4 == 0);
      default: tick = 1'b0;
    endcase
  end

  // ---------------- behavioural model ----------------
  // k = number of ticks since the frame was accepted. Tick 1 is the
  // preamble, ticks 2..25 carry frame bits 23..0, tick 25+GAP ends the frame.
  int          m_k = 0;
  bit          m_busy = 0, m_done = 0;
  logic [23:0] m_frame = '0;
  logic        e_sdo = IDLE, e_le = 0, e_busy = 0, e_done = 0, e_drop = 0;

  always @(posedge clk) begin : model
    int k;
    bit b, d, dr;
    logic [23:0] f;
    k = m_k; b = m_busy; f = m_frame; d = 0; dr = 0;
    if (reset) begin
      k = 0; b = 0; f = '0;
    end else begin
      dr = start && (m_busy || m_done);
      if (!m_busy && start && !m_done) begin
        b = 1; k = 0; f = {8'(w), 8'(lk), thr};
      end else if (m_busy && tick) begin
        k++;
        if (k == 25 + GAP) begin d = 1; b = 0; end
      end
    end
    m_k <= k; m_busy <= b; m_done <= d; m_frame <= f;
    e_busy <= b; e_done <= d; e_drop <= dr;
    e_le   <= b && k >= 1 && k <= 25;
    e_sdo  <= (b && k >= 2 && k <= 25) ? f[25-k] : IDLE;
  end

  // ---------------- checking ----------------
  int checks = 0, failures = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("serial_data_out", sdo,  e_sdo);
      chk("load_enable_out", le,   e_le);
      chk("busy",            busy, e_busy);
      chk("done",            done, e_done);
      chk("start_dropped",   drop, e_drop);
    end
  end

  // ---------------- stream monitor (plays the receiver) ----------------
  logic bitq[$];
  int   le_cycles = 0, done_cnt = 0, drop_cnt = 0, ticks_in = 0, rises = 0;
  int   last_le = 0, rise_cyc = 0;
  logic tick_e = 0;
  bit   busy_prev = 0, le_prev = 0;

  always @(posedge clk) tick_e <= tick;

  always @(negedge clk) begin
    if (tick_e && le) bitq.push_back(sdo);
    if (le) begin le_cycles++; last_le = cyc; end
    if (le && !le_prev) begin rises++; rise_cyc = cyc; end
    if (done) done_cnt++;
    if (drop) drop_cnt++;
    if (tick_e && busy_prev) ticks_in++;
    busy_prev = busy;
    le_prev   = le;
  end

  task automatic clr_mon();
    bitq.delete();
    le_cycles = 0; done_cnt = 0; drop_cnt = 0; ticks_in = 0; rises = 0;
  endtask

  // 24 data bits of the frame starting at queue position base+1 (base = preamble)
  function automatic logic [23:0] frame_at(input int base);
    logic [23:0] v = '0;
    for (int i = 1; i <= 24; i++)
      if (base + i < bitq.size()) v = {v[22:0], bitq[base+i]};
    return v;
  endfunction

  int start_cyc = 0, done_at = 0;

  task automatic send(input logic [2:0] sw, input logic [1:0] sl, input logic [7:0] st);
    @(negedge clk);
    clr_mon();
    w = sw; lk = sl; thr = st; start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // returns in the negedge where done is observed
  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s timeout waiting for done after %0d cycles", name, budget);
    end
    done_at = cyc;
  endtask

  task automatic wait_bits(input string name, input int nbits, input int budget);
    int n = 0;
    while (bitq.size() < nbits && n < budget) begin @(negedge clk); n++; end
    if (bitq.size() < nbits) begin
      checks++; failures++;
      $display("FAIL %s timeout waiting for %0d bits, got %0d", name, nbits, bitq.size());
    end
  endtask

  initial begin
    int last1, gap_low;
    logic [23:0] rx;

    // reset
    reset = 1'b1;
    @(negedge clk);
    cmp_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_le", le, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sdo", sdo, IDLE);
    chk("rst_done", done, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // continuous tick, w=5 leak=2 thr=0x96
    send(3'd5, 2'd2, 8'h96);
    wait_done("t1", 100);
    chk("t1_done_latency", done_at - start_cyc, 28);
    @(negedge clk);
    chk("t1_nbits", bitq.size(), 25);
    chk("t1_preamble", bitq[0], IDLE);
    chk("t1_data", frame_at(0), 24'b00000101_00000010_10010110);
    chk("t1_le_cycles", le_cycles, 25);
    chk("t1_drops", drop_cnt, 0);

    // tick every 4th clk, same parameters
    tick_mode = 1;
    repeat (4) @(negedge clk);
    send(3'd5, 2'd2, 8'h96);
    wait_done("t2", 400);
    @(negedge clk);
    chk("t2_data", frame_at(0), 24'h050296);
    chk("t2_le_cycles", le_cycles, 100);
    chk("t2_ticks_to_done", ticks_in, 27);

    // loopback decode with a tick stall mid-frame
    tick_mode = 0;
    repeat (2) @(negedge clk);
    send(3'd3, 2'd1, 8'd200);
    repeat (8) @(negedge clk);
    tick_mode = 2;
    repeat (20) @(negedge clk);
    tick_mode = 0;
    wait_done("t3", 100);
    @(negedge clk);
    rx = frame_at(0);
    chk("t3_params_ready", bitq.size(), 25);
    chk("t3_weight", rx[18:16], 3);
    chk("t3_leak", rx[9:8], 1);
    chk("t3_threshold", rx[7:0], 200);

    // start again mid-frame with a different weight
    send(3'd5, 2'd2, 8'h96);
    wait_bits("t4", 11, 50);
    w = 3'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4", 100);
    repeat (40) @(negedge clk);
    chk("t4_drops", drop_cnt, 1);
    chk("t4_data", frame_at(0), 24'h050296);
    chk("t4_frames", rises, 1);
    chk("t4_dones", done_cnt, 1);

    // reset in the middle of a frame, then a fresh frame
    send(3'd5, 2'd2, 8'h96);
    wait_bits("t5", 16, 50);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_le_after_rst", le, 0);
    chk("t5_busy_after_rst", busy, 0);
    repeat (40) @(negedge clk);
    chk("t5_no_done", done_cnt, 0);
    send(3'd6, 2'd3, 8'h5A);
    wait_done("t5b", 100);
    @(negedge clk);
    chk("t5_fresh_data", frame_at(0), 24'h06035A);

    // back-to-back frames, start in the first cycle after done
    send(3'd1, 2'd0, 8'h0F);
    wait_done("t6a", 100);
    @(negedge clk);
    last1 = last_le;
    w = 3'd2; lk = 2'd3; thr = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6b", 100);
    // start in the done cycle itself must be refused
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    // low cycles: GAP ticks (the done cycle is the last), the idle cycle
    // carrying start, and the accept cycle before the preamble tick
    gap_low = rise_cyc - last1 - 1;
    chk("t6_gap_low_cycles", gap_low, GAP + 2);
    chk("t6_frame1", frame_at(0), 24'h01000F);
    chk("t6_frame2", frame_at(25), 24'h0203A5);
    chk("t6_frames", rises, 2);
    chk("t6_drop_at_done", drop_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
